// File: rtl/irq_pkg.sv
// Shared sizes and vector types for the interrupt pending controller.
package irq_pkg;

    localparam int NUM_IRQ = 8;
    localparam int ID_W    = $clog2(NUM_IRQ);

    typedef logic [NUM_IRQ-1:0] irq_vec_t;
    typedef logic [ID_W-1:0]    irq_id_t;

endpackage

// File: rtl/irq_priority_select.sv
// Combinational MSB-first selector: reports the highest set request line.
module irq_priority_select
    import irq_pkg::*;
(
    input  irq_vec_t req,
    output logic     valid,
    output irq_id_t  id
);

    // Ascending scan so the highest set line is the last one written.
    always_comb begin
        valid = 1'b0;
        id    = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (req[i]) begin
                valid = 1'b1;
                id    = irq_id_t'(i);
            end
        end
    end

endmodule

// File: rtl/irq_pending_ctrl.sv
// Interrupt front-end: sticky pending capture, mask/in-service blocking and a
// registered valid/ready presentation port with one bubble after each accept.
module irq_pending_ctrl
    import irq_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  irq_vec_t irq_in,
    input  irq_vec_t edge_mode,
    input  irq_vec_t irq_mask,
    output logic     irq_valid,
    output irq_id_t  irq_id,
    input  logic     irq_ready,
    input  logic     eoi_valid,
    input  irq_id_t  eoi_id,
    output irq_vec_t pending,
    output irq_vec_t in_service
);

    irq_vec_t irq_q;
    irq_vec_t rise;
    irq_vec_t accept_vec;
    irq_vec_t eoi_vec;
    irq_vec_t eligible;
    irq_vec_t pending_nxt;
    logic     accept;
    logic     sel_valid;
    irq_id_t  sel_id;

    assign rise       = irq_in & ~irq_q;
    assign accept     = irq_valid & irq_ready;
    assign accept_vec = accept ? (irq_vec_t'(1) << irq_id) : '0;
    assign eoi_vec    = eoi_valid ? (irq_vec_t'(1) << eoi_id) : '0;
    assign eligible   = pending & ~irq_mask & ~in_service;

    // A fresh edge outranks the clear from accepting that same line.
    assign pending_nxt = (edge_mode & (rise | (pending & ~accept_vec)))
                       | (~edge_mode & irq_in);

    irq_priority_select u_select (
        .req   (eligible),
        .valid (sel_valid),
        .id    (sel_id)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q      <= '0;
            pending    <= '0;
            in_service <= '0;
        end else begin
            irq_q      <= irq_in;
            pending    <= pending_nxt;
            in_service <= (in_service & ~eoi_vec) | accept_vec;
        end
    end

    // Presented id is frozen until accepted; accept forces one idle cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_valid <= 1'b0;
            irq_id    <= '0;
        end else if (!irq_valid) begin
            irq_valid <= sel_valid;
            irq_id    <= sel_id;
        end else if (irq_ready) begin
            irq_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Self-checking bench for irq_pending_ctrl: directed scenarios with literal
// expectations plus a randomized run compared every cycle to a line-by-line model.
module tb_irq_pending_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] irq_in;
    logic [7:0] edge_mode;
    logic [7:0] irq_mask;
    logic       irq_valid;
    logic [2:0] irq_id;
    logic       irq_ready;
    logic       eoi_valid;
    logic [2:0] eoi_id;
    logic [7:0] pending;
    logic [7:0] in_service;

    int n_checks = 0;
    int n_pass   = 0;

    irq_pending_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .irq_in     (irq_in),
        .edge_mode  (edge_mode),
        .irq_mask   (irq_mask),
        .irq_valid  (irq_valid),
        .irq_id     (irq_id),
        .irq_ready  (irq_ready),
        .eoi_valid  (eoi_valid),
        .eoi_id     (eoi_id),
        .pending    (pending),
        .in_service (in_service)
    );

    always #5 clk = ~clk;

    // Reference model state, one bit per line.
    logic [7:0] m_q, m_pend, m_isv, n_pend, n_isv;
    logic       m_valid, m_acc;
    int         m_id;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q = '0; m_pend = '0; m_isv = '0; m_valid = 1'b0; m_id = 0;
        end else begin
            m_acc = m_valid && irq_ready;
            for (int i = 0; i < 8; i++) begin
                if (edge_mode[i]) begin
                    if (irq_in[i] && !m_q[i])      n_pend[i] = 1'b1;
                    else if (m_acc && m_id == i)   n_pend[i] = 1'b0;
                    else                           n_pend[i] = m_pend[i];
                end else begin
                    n_pend[i] = irq_in[i];
                end
            end
            n_isv = m_isv;
            if (eoi_valid) n_isv[eoi_id] = 1'b0;
            if (m_acc)     n_isv[m_id]   = 1'b1;
            if (!m_valid) begin
                for (int i = 7; i >= 0; i--) begin
                    if (!m_valid && m_pend[i] && !irq_mask[i] && !m_isv[i]) begin
                        m_valid = 1'b1;
                        m_id    = i;
                    end
                end
            end else if (m_acc) begin
                m_valid = 1'b0;
            end
            m_pend = n_pend;
            m_isv  = n_isv;
            m_q    = irq_in;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(posedge clk) begin
        #1;
        checkOutput("model.irq_valid", 32'(irq_valid), 32'(m_valid));
        checkOutput("model.pending", 32'(pending), 32'(m_pend));
        checkOutput("model.in_service", 32'(in_service), 32'(m_isv));
        if (m_valid) checkOutput("model.irq_id", 32'(irq_id), 32'(m_id));
        else if (!rst_n) checkOutput("model.irq_id_rst", 32'(irq_id), 32'd0);
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic doReset(input logic [7:0] mode);
        rst_n = 1'b0; irq_in = '0; edge_mode = mode; irq_mask = '0;
        irq_ready = 1'b0; eoi_valid = 1'b0; eoi_id = '0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic applyStimulus(input int cyc);
        if (cyc % 256 == 0) edge_mode = 8'($urandom);
        if ($urandom_range(0, 3) == 0) irq_in = 8'($urandom);
        if ($urandom_range(0, 15) == 0) irq_mask = 8'($urandom & $urandom);
        irq_ready = ($urandom_range(0, 2) != 0);
        eoi_valid = ($urandom_range(0, 3) == 0);
        eoi_id    = 3'($urandom_range(0, 7));
        rst_n     = !(cyc % 700 == 699);
    endtask

    initial begin
        // Scenario 1: level lines all high through reset.
        rst_n = 1'b0; irq_in = 8'hFF; edge_mode = 8'h00; irq_mask = '0;
        irq_ready = 1'b0; eoi_valid = 1'b0; eoi_id = '0;
        tick(3);
        checkOutput("s1.valid_in_reset", 32'(irq_valid), 32'd0);
        checkOutput("s1.pending_in_reset", 32'(pending), 32'h00);
        rst_n = 1'b1;
        tick(1);
        checkOutput("s1.valid_1", 32'(irq_valid), 32'd0);
        checkOutput("s1.pending_1", 32'(pending), 32'hFF);
        tick(1);
        checkOutput("s1.valid_2", 32'(irq_valid), 32'd1);
        checkOutput("s1.id_2", 32'(irq_id), 32'd7);

        // Scenario 2: edge pulses on lines 3 and 5, ready held.
        doReset(8'hFF);
        irq_in = 8'h28; irq_ready = 1'b1;
        tick(1);
        irq_in = 8'h00;
        checkOutput("s2.pending", 32'(pending), 32'h28);
        tick(1);
        checkOutput("s2.first_id", 32'(irq_id), 32'd5);
        checkOutput("s2.first_valid", 32'(irq_valid), 32'd1);
        tick(1);
        checkOutput("s2.bubble", 32'(irq_valid), 32'd0);
        tick(1);
        checkOutput("s2.second_id", 32'(irq_id), 32'd3);
        checkOutput("s2.second_valid", 32'(irq_valid), 32'd1);
        tick(1);
        checkOutput("s2.in_service", 32'(in_service), 32'h28);
        checkOutput("s2.pending_after", 32'(pending), 32'h00);

        // Scenario 3: masked pending line stays pending, unmask presents it.
        doReset(8'hFF);
        irq_mask = 8'h04; irq_in = 8'h04;
        tick(1);
        irq_in = 8'h00;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            checkOutput("s3.masked_valid", 32'(irq_valid), 32'd0);
            checkOutput("s3.masked_pending2", 32'(pending[2]), 32'd1);
        end
        irq_mask = 8'h00;
        tick(1);
        checkOutput("s3.unmask_valid", 32'(irq_valid), 32'd1);
        checkOutput("s3.unmask_id", 32'(irq_id), 32'd2);

        // Scenario 4: presented id holds while a higher line arrives.
        doReset(8'hFF);
        irq_in = 8'h02;
        tick(2);
        checkOutput("s4.id1", 32'(irq_id), 32'd1);
        irq_in = 8'h40;
        tick(1);
        irq_in = 8'h00;
        tick(2);
        checkOutput("s4.hold_id", 32'(irq_id), 32'd1);
        checkOutput("s4.hold_valid", 32'(irq_valid), 32'd1);
        irq_ready = 1'b1;
        tick(1);
        irq_ready = 1'b0;
        checkOutput("s4.bubble", 32'(irq_valid), 32'd0);
        tick(1);
        checkOutput("s4.next_id", 32'(irq_id), 32'd6);
        checkOutput("s4.next_valid", 32'(irq_valid), 32'd1);

        // Scenario 5: level line blocked while in service, re-presented after EOI.
        doReset(8'h00);
        irq_in = 8'h10;
        tick(2);
        checkOutput("s5.id4", 32'(irq_id), 32'd4);
        irq_ready = 1'b1;
        tick(1);
        irq_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            checkOutput("s5.blocked_valid", 32'(irq_valid), 32'd0);
            checkOutput("s5.in_service", 32'(in_service), 32'h10);
        end
        eoi_valid = 1'b1; eoi_id = 3'd4;
        tick(1);
        eoi_valid = 1'b0;
        checkOutput("s5.eoi_cleared", 32'(in_service), 32'h00);
        tick(1);
        checkOutput("s5.represent_valid", 32'(irq_valid), 32'd1);
        checkOutput("s5.represent_id", 32'(irq_id), 32'd4);

        // Scenario 6: new edge on line 0 in its own accept cycle is kept.
        doReset(8'hFF);
        irq_in = 8'h01;
        tick(1);
        irq_in = 8'h00;
        tick(1);
        checkOutput("s6.id0", 32'(irq_id), 32'd0);
        irq_ready = 1'b1; irq_in = 8'h01;
        tick(1);
        irq_ready = 1'b0; irq_in = 8'h00;
        checkOutput("s6.pending_kept", 32'(pending), 32'h01);
        checkOutput("s6.in_service", 32'(in_service), 32'h01);
        tick(2);
        checkOutput("s6.blocked", 32'(irq_valid), 32'd0);
        eoi_valid = 1'b1; eoi_id = 3'd0;
        tick(1);
        eoi_valid = 1'b0;
        tick(1);
        checkOutput("s6.represent_valid", 32'(irq_valid), 32'd1);
        checkOutput("s6.represent_id", 32'(irq_id), 32'd0);

        // Randomized run, checked by the per-cycle model comparison.
        doReset(8'($urandom));
        for (int cyc = 0; cyc < 3000; cyc++) begin
            applyStimulus(cyc);
            tick(1);
        end
        rst_n = 1'b1;
        tick(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
